// File: rtl/pic_rom_grey_reader.sv
// Picture-ROM fetch stage: derives window coordinates from DE/HS/VS, reads the
// RGB888 ROM and emits colour or greyscale pixels with syncs delayed 4 clocks.
module pic_rom_grey_reader #(
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned X_START  = 0,
  parameter int unsigned Y_START  = 0,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs_in,
  input  logic        hs_in,
  input  logic        de_in,
  input  logic        grey_en,
  output logic [15:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [23:0] rgb_out
);

  localparam int unsigned NPIX     = IMG_W * IMG_H;
  localparam logic [15:0] ADDR_MAX = 16'(NPIX - 1);
  localparam logic [12:0] X_LO     = 13'(X_START);
  localparam logic [12:0] X_HI     = 13'(X_START + IMG_W);
  localparam logic [12:0] Y_LO     = 13'(Y_START);
  localparam logic [12:0] Y_HI     = 13'(Y_START + IMG_H);

  logic [11:0] x;
  logic [11:0] y;
  logic        de_d;
  logic        lock;
  logic [15:0] addr_cnt;
  logic        win;

  // Control pipeline, packed as {vs, hs, de, win, grey}.
  logic [4:0]  p1, p2, p3;
  logic        live1, live2, live3;
  logic [15:0] pr, pg, pb;
  logic [23:0] raw;
  logic [7:0]  luma;

  always_comb begin
    win = lock && de_in
          && ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI)
          && ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
  end

  always_comb begin
    luma = 8'((pr + pg + pb + 16'd128) >> 8);
  end

  // rom_addr latches the current pixel's address; addr_cnt already points at the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      de_d     <= 1'b0;
      lock     <= 1'b0;
      addr_cnt <= '0;
      rom_addr <= '0;
    end else begin
      de_d <= de_in;
      x    <= de_in ? x + 12'd1 : '0;
      if (vs_in) begin
        y <= '0;
      end else if (de_d && !de_in) begin
        y <= y + 12'd1;
      end
      if (vs_in) begin
        lock <= 1'b1;
      end
      if (vs_in) begin
        addr_cnt <= '0;
        rom_addr <= '0;
      end else if (win) begin
        rom_addr <= addr_cnt;
        addr_cnt <= (addr_cnt == ADDR_MAX) ? '0 : addr_cnt + 16'd1;
      end
    end
  end

  // live* tracks pipeline fill after reset so the first 4 outputs stay zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1      <= '0;
      p2      <= '0;
      p3      <= '0;
      live1   <= 1'b0;
      live2   <= 1'b0;
      live3   <= 1'b0;
      pr      <= '0;
      pg      <= '0;
      pb      <= '0;
      raw     <= '0;
      vs_out  <= 1'b0;
      hs_out  <= 1'b0;
      de_out  <= 1'b0;
      rgb_out <= '0;
    end else begin
      p1    <= {vs_in, hs_in, de_in, win, grey_en};
      p2    <= p1;
      p3    <= p2;
      live1 <= 1'b1;
      live2 <= live1;
      live3 <= live2;
      pr    <= 16'(rom_data[23:16]) * 16'd77;
      pg    <= 16'(rom_data[15:8]) * 16'd150;
      pb    <= 16'(rom_data[7:0]) * 16'd29;
      raw   <= rom_data;
      vs_out <= p3[4];
      hs_out <= p3[3];
      de_out <= p3[2];
      if (!live3) begin
        rgb_out <= '0;
      end else if (p3[1]) begin
        rgb_out <= p3[0] ? {luma, luma, luma} : raw;
      end else begin
        rgb_out <= BG_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_pic_rom_grey_reader.sv
// Randomised raster bench for pic_rom_grey_reader with a per-cycle
// behavioural model and a negedge compare process.
module tb_pic_rom_grey_reader;

  localparam int unsigned W  = 16;
  localparam int unsigned H  = 8;
  localparam int unsigned XS = 3;
  localparam int unsigned YS = 2;
  localparam int unsigned N  = W * H;
  localparam logic [23:0] BG = 24'h203040;
  localparam int MAXC = 8192;

  logic        clk;
  logic        rst;
  logic        vs_in, hs_in, de_in, grey_en;
  logic [15:0] rom_addr;
  logic [23:0] rom_data;
  logic        vs_out, hs_out, de_out;
  logic [23:0] rgb_out;

  pic_rom_grey_reader #(
    .IMG_W(W), .IMG_H(H), .X_START(XS), .Y_START(YS), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .grey_en(grey_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .rgb_out(rgb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] rom_mem [N];
  always @(posedge clk) rom_data <= rom_mem[int'(rom_addr) % N];

  // Per-cycle records produced by the model.
  logic [23:0] e_rgb  [MAXC];
  logic [15:0] e_addr [MAXC];
  bit          e_vs [MAXC], e_hs [MAXC], e_de [MAXC];
  bit          r_rst [MAXC], r_win [MAXC], r_grey [MAXC];
  int          r_a [MAXC];
  logic [23:0] lit_grey [4];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit rst_drv;

  int          m_px, m_line, m_cnt;
  bit          m_lock, m_prev_de;
  logic [15:0] m_addr_reg;

  function automatic logic [7:0] grey_of(logic [23:0] c);
    int s;
    s = 77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0]) + 128;
    return 8'(s / 256);
  endfunction

  task automatic model_reset();
    m_px = 0; m_line = 0; m_cnt = 0; m_lock = 0; m_prev_de = 0; m_addr_reg = '0;
  endtask

  task automatic step(input bit v, input bit h, input bit d, input bit g);
    int t;
    bit w;
    int a;
    t = cyc;
    if (t >= MAXC) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", t, MAXC);
      $fatal(1);
    end
    rst = rst_drv; vs_in = v; hs_in = h; de_in = d; grey_en = g;
    r_rst[t] = rst_drv;
    if (rst_drv) begin
      model_reset();
      e_rgb[t] = '0; e_vs[t] = 0; e_hs[t] = 0; e_de[t] = 0;
      e_addr[t] = '0; r_win[t] = 0; r_grey[t] = 0; r_a[t] = 0;
    end else begin
      w = m_lock && d && m_px >= XS && m_px < XS + W && m_line >= YS && m_line < YS + H;
      a = m_cnt;
      e_rgb[t] = w ? (g ? {3{grey_of(rom_mem[a])}} : rom_mem[a]) : BG;
      e_vs[t] = v; e_hs[t] = h; e_de[t] = d;
      r_win[t] = w; r_grey[t] = g; r_a[t] = a;
      if (v) m_addr_reg = '0;
      else if (w) m_addr_reg = 16'(a);
      e_addr[t] = m_addr_reg;
      if (v) m_cnt = 0;
      else if (w) m_cnt = (m_cnt + 1) % N;
      if (m_prev_de && !d) m_line++;
      if (v) m_line = 0;
      m_px = d ? m_px + 1 : 0;
      m_prev_de = d;
      if (v) m_lock = 1;
    end
    cyc = t + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc - 1, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      int t;
      t = cyc - 1;
      if (r_rst[t]) begin
        check("reset_rgb", rgb_out, 24'h0);
        check("reset_addr", {8'h0, rom_addr}, 24'h0);
        check("reset_sync", {21'h0, vs_out, hs_out, de_out}, 24'h0);
      end else if (t >= 4) begin
        check("rgb", rgb_out, e_rgb[t-4]);
        check("sync", {21'h0, vs_out, hs_out, de_out}, {21'h0, e_vs[t-4], e_hs[t-4], e_de[t-4]});
        check("rom_addr", {8'h0, rom_addr}, {8'h0, e_addr[t-1]});
        if (!r_rst[t-4] && r_win[t-4]) begin
          if (r_grey[t-4] && r_a[t-4] < 4) check("grey_literal", rgb_out, lit_grey[r_a[t-4]]);
          if (!r_grey[t-4] && r_a[t-4] == 4) check("colour_literal", rgb_out, 24'h123456);
        end
      end
    end
  end

  function automatic bit pick_grey(int gmode);
    return (gmode == 2) ? bit'($urandom_range(0, 1)) : bit'(gmode);
  endfunction

  // gmode: 0 colour, 1 grey, 2 random per pixel (also random line lengths and DE gaps).
  task automatic frame(input int gmode, input bit with_vs, input int rst_line);
    int nl, len, gap_at, rst_px;
    if (with_vs) begin
      repeat (2) step(1, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0);
    end
    nl = YS + H + 2;
    for (int l = 0; l < nl; l++) begin
      repeat (2) step(0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0);
      len = (gmode == 2) ? int'($urandom_range(8, 24)) : int'(XS + W + 2);
      gap_at = (gmode == 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1;
      rst_px = (l == rst_line) ? 6 : -1;
      for (int i = 0; i < len; i++) begin
        if (i == gap_at) step(0, 0, 0, 0);
        if (i == rst_px) begin
          rst_drv = 1;
          repeat (5) step(0, 0, 0, 0);
          rst_drv = 0;
        end
        step(0, 0, 1, pick_grey(gmode));
      end
      repeat (2) step(0, 0, 0, 0);
    end
  endtask

  initial begin
    rom_mem[0] = 24'hFFFFFF;
    rom_mem[1] = 24'hFF0000;
    rom_mem[2] = 24'h00FF00;
    rom_mem[3] = 24'h0000FF;
    rom_mem[4] = 24'h123456;
    for (int i = 5; i < int'(N); i++) rom_mem[i] = 24'($urandom);
    lit_grey[0] = 24'hFFFFFF;
    lit_grey[1] = 24'h4D4D4D;
    lit_grey[2] = 24'h959595;
    lit_grey[3] = 24'h1D1D1D;
    rst = 1; vs_in = 0; hs_in = 0; de_in = 0; grey_en = 0;
    model_reset();
    rst_drv = 1;
    @(posedge clk);
    #1;
    repeat (5) step(0, 0, 0, 0);
    rst_drv = 0;
    frame(2, 0, -1);
    frame(1, 1, -1);
    frame(0, 1, -1);
    frame(2, 1, -1);
    frame(2, 1, 5);
    frame(2, 0, -1);
    frame(1, 1, -1);
    frame(2, 1, -1);
    repeat (8) step(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
